// File: rtl/sg_table_loader.sv
// Framed byte-stream loader for the signal generator's eight-point waveform table.
// Optional checksum byte and check enabled by defining SG_LOADER_CHECKSUM_EN.
module sg_table_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [7:0]  HEADER_BYTE    = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  controlstate,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [11:0] sgDP0,
    output logic [11:0] sgDP1,
    output logic [11:0] sgDP2,
    output logic [11:0] sgDP3,
    output logic [11:0] sgDP4,
    output logic [11:0] sgDP5,
    output logic [11:0] sgDP6,
    output logic [11:0] sgDP7,
    output logic        table_valid,
    output logic        load_done,
    output logic        load_err
);

    typedef enum logic [1:0] {StIdle, StData, StCsum, StCommit} state_t;

    localparam logic [16:0] TmoLimit = 17'(TIMEOUT_CYCLES);

    state_t      state;
    logic [3:0]  idx;
    logic [15:0] tmo_cnt;
    logic [11:0] shadow [8];
    logic        accept;
    logic [16:0] tmo_next;

    assign byte_ready = (state != StCommit) && !rst;
    assign accept     = byte_valid && byte_ready;
    assign tmo_next   = {1'b0, tmo_cnt} + 17'd1;

`ifdef SG_LOADER_CHECKSUM_EN
    logic [7:0] sum;
    logic [7:0] sum_total;
    assign sum_total = sum + byte_in;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            idx         <= 4'd0;
            tmo_cnt     <= 16'd0;
            table_valid <= 1'b0;
            load_done   <= 1'b0;
            load_err    <= 1'b0;
            sgDP0 <= 12'h000; sgDP1 <= 12'h000; sgDP2 <= 12'h000; sgDP3 <= 12'h000;
            sgDP4 <= 12'h000; sgDP5 <= 12'h000; sgDP6 <= 12'h000; sgDP7 <= 12'h000;
            for (int i = 0; i < 8; i++) shadow[i] <= 12'h000;
`ifdef SG_LOADER_CHECKSUM_EN
            sum <= 8'h00;
`endif
        end else begin
            load_done <= 1'b0;
            load_err  <= 1'b0;
            case (state)
                StIdle: begin
                    tmo_cnt <= 16'd0;
                    if (accept && byte_in == HEADER_BYTE) begin
                        idx   <= 4'd0;
                        state <= StData;
`ifdef SG_LOADER_CHECKSUM_EN
                        sum <= HEADER_BYTE;
`endif
                    end
                end
                StData: begin
                    if (accept) begin
                        tmo_cnt <= 16'd0;
                        // High byte of each point carries only a nibble.
                        if (!idx[0] && byte_in[7:4] != 4'h0) begin
                            load_err <= 1'b1;
                            state    <= StIdle;
                            for (int i = 0; i < 8; i++) shadow[i] <= 12'h000;
                        end else begin
                            if (!idx[0]) shadow[idx[3:1]][11:8] <= byte_in[3:0];
                            else         shadow[idx[3:1]][7:0]  <= byte_in;
                            idx <= idx + 4'd1;
`ifdef SG_LOADER_CHECKSUM_EN
                            sum <= sum_total;
                            if (idx == 4'd15) state <= StCsum;
`else
                            if (idx == 4'd15) state <= StCommit;
`endif
                        end
                    end else if (tmo_next >= TmoLimit) begin
                        load_err <= 1'b1;
                        state    <= StIdle;
                        tmo_cnt  <= 16'd0;
                        for (int i = 0; i < 8; i++) shadow[i] <= 12'h000;
                    end else begin
                        tmo_cnt <= tmo_next[15:0];
                    end
                end
`ifdef SG_LOADER_CHECKSUM_EN
                StCsum: begin
                    if (accept) begin
                        tmo_cnt <= 16'd0;
                        if (sum_total == 8'h00) begin
                            state <= StCommit;
                        end else begin
                            load_err <= 1'b1;
                            state    <= StIdle;
                            for (int i = 0; i < 8; i++) shadow[i] <= 12'h000;
                        end
                    end else if (tmo_next >= TmoLimit) begin
                        load_err <= 1'b1;
                        state    <= StIdle;
                        tmo_cnt  <= 16'd0;
                        for (int i = 0; i < 8; i++) shadow[i] <= 12'h000;
                    end else begin
                        tmo_cnt <= tmo_next[15:0];
                    end
                end
`endif
                StCommit: begin
                    // Never swap the table under a playing generator.
                    if (controlstate != 4'h7) begin
                        sgDP0 <= shadow[0]; sgDP1 <= shadow[1];
                        sgDP2 <= shadow[2]; sgDP3 <= shadow[3];
                        sgDP4 <= shadow[4]; sgDP5 <= shadow[5];
                        sgDP6 <= shadow[6]; sgDP7 <= shadow[7];
                        table_valid <= 1'b1;
                        load_done   <= 1'b1;
                        state       <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sg_table_loader.sv
// Directed self-checking bench for sg_table_loader (timeout shortened to 8 cycles).
module tb_sg_table_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  controlstate = 4'h0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic [11:0] sgDP0, sgDP1, sgDP2, sgDP3, sgDP4, sgDP5, sgDP6, sgDP7;
    logic        table_valid, load_done, load_err;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int exp_err = 0;

    sg_table_loader #(
        .TIMEOUT_CYCLES(8),
        .HEADER_BYTE   (8'hA5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .controlstate(controlstate),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .sgDP0       (sgDP0),
        .sgDP1       (sgDP1),
        .sgDP2       (sgDP2),
        .sgDP3       (sgDP3),
        .sgDP4       (sgDP4),
        .sgDP5       (sgDP5),
        .sgDP6       (sgDP6),
        .sgDP7       (sgDP7),
        .table_valid (table_valid),
        .load_done   (load_done),
        .load_err    (load_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (load_done) done_cnt++;
        if (load_err) err_cnt++;
        if (load_done && load_err) both_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [11:0] pt, input logic [7:0] cs);
        send(8'hA5);
        for (int k = 0; k < 8; k++) begin
            send({4'h0, pt[11:8]});
            send(pt[7:0]);
        end
`ifdef SG_LOADER_CHECKSUM_EN
        send(cs);
`endif
    endtask

    task automatic check_table(input string tag, input logic [11:0] pt);
        check_eq({tag, "_dp0"}, {20'h0, sgDP0}, {20'h0, pt});
        check_eq({tag, "_dp3"}, {20'h0, sgDP3}, {20'h0, pt});
        check_eq({tag, "_dp7"}, {20'h0, sgDP7}, {20'h0, pt});
    endtask

    task automatic expect_commit(input string tag, input logic [11:0] pt);
        check_eq({tag, "_ready_low"}, {31'h0, byte_ready}, 32'h0);
        check_eq({tag, "_no_early_done"}, {31'h0, load_done}, 32'h0);
        @(posedge clk);
        #1;
        check_eq({tag, "_done"}, {31'h0, load_done}, 32'h1);
        check_eq({tag, "_valid"}, {31'h0, table_valid}, 32'h1);
        check_table(tag, pt);
        @(posedge clk);
        #1;
        check_eq({tag, "_done_one_cycle"}, {31'h0, load_done}, 32'h0);
        check_eq({tag, "_ready_back"}, {31'h0, byte_ready}, 32'h1);
    endtask

    initial begin
        // Reset
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", {31'h0, byte_ready}, 32'h0);
        check_eq("rst_valid", {31'h0, table_valid}, 32'h0);
        check_eq("rst_done", {31'h0, load_done}, 32'h0);
        check_eq("rst_err", {31'h0, load_err}, 32'h0);
        check_table("rst", 12'h000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("ready_after_rst", {31'h0, byte_ready}, 32'h1);

        // Junk in IDLE is dropped silently
        send(8'h00);
        send(8'hFF);
        send(8'h5A);
        @(posedge clk);
        #1;
        check_eq("junk_no_err", err_cnt, 0);
        check_eq("junk_ready", {31'h0, byte_ready}, 32'h1);

`ifdef SG_LOADER_CHECKSUM_EN
        send_frame(12'h123, 8'h3C);
        exp_err++;
        check_eq("csum_err", {31'h0, load_err}, 32'h1);
        check_table("csum_keep", 12'h000);
        check_eq("csum_valid", {31'h0, table_valid}, 32'h0);
        @(posedge clk);
        #1;
        check_eq("csum_err_one_cycle", {31'h0, load_err}, 32'h0);
`endif

        // Good frame
        send_frame(12'h123, 8'h3B);
        expect_commit("good", 12'h123);

        // Format error at data index 4
        send(8'hA5);
        send(8'h01);
        send(8'h23);
        send(8'h01);
        send(8'h23);
        send(8'h1F);
        exp_err++;
        check_eq("fmt_err", {31'h0, load_err}, 32'h1);
        check_table("fmt_keep", 12'h123);
        check_eq("fmt_valid", {31'h0, table_valid}, 32'h1);

        // Commit held off during playback
        controlstate = 4'h7;
        send_frame(12'hFFF, 8'hEB);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check_eq("hold_ready", {31'h0, byte_ready}, 32'h0);
            check_eq("hold_done", {31'h0, load_done}, 32'h0);
            check_eq("hold_dp0", {20'h0, sgDP0}, 32'h123);
        end
        @(negedge clk);
        controlstate = 4'h5;
        @(posedge clk);
        #1;
        check_eq("hold_commit_done", {31'h0, load_done}, 32'h1);
        check_table("hold_commit", 12'hFFF);

        // Timeout after three data bytes
        send(8'hA5);
        send(8'h01);
        send(8'h23);
        send(8'h01);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            check_eq("tmo_err", {31'h0, load_err}, (k == 8) ? 32'h1 : 32'h0);
        end
        exp_err++;
        check_table("tmo_keep", 12'hFFF);
        send_frame(12'h123, 8'h3B);
        expect_commit("after_tmo", 12'h123);

        // Reset mid-frame
        send(8'hA5);
        send(8'h01);
        send(8'h23);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("midrst_ready", {31'h0, byte_ready}, 32'h0);
        check_eq("midrst_valid", {31'h0, table_valid}, 32'h0);
        check_eq("midrst_err", {31'h0, load_err}, 32'h0);
        check_table("midrst", 12'h000);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("total_done", done_cnt, 3);
        check_eq("total_err", err_cnt, exp_err);
        check_eq("never_both", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sg_table_loader.md
# sg_table_loader

Upstream feeder for the signal generator: receives a framed byte stream from the host link, assembles eight 12-bit waveform points, and verifies them. It then presents the points on `sgDP0`..`sgDP7` with a validity flag. The live table is updated atomically, and never while the generator is playing back (`controlstate == 4'h7`), so the generator always latches a complete, consistent table in its load state.

## Interface
- `TIMEOUT_CYCLES`, 1024: idle clocks allowed between accepted bytes mid-frame before abort; range 1..65535.
- `HEADER_BYTE`, 8'hA5: frame start marker.

- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `controlstate`  in  4  top-level control state; `4'h7` = playback active.
- `byte_in`  in  8  incoming stream byte.
- `byte_valid`  in  1  `byte_in` valid this cycle.
- `byte_ready`  out  1  loader can accept; a byte transfers on a rising edge with `byte_valid && byte_ready`.
- `sgDP0`..`sgDP7`  out  12 each  live waveform points.
- `table_valid`  out  1  a verified table has been committed since reset.
- `load_done`  out  1  one-cycle pulse on commit.
- `load_err`  out  1  one-cycle pulse on frame abort.

## Operation
- States: IDLE, DATA, CSUM, COMMIT.
- IDLE:
  - Accepted byte == `HEADER_BYTE`: clear the byte index and running sum, add the header to the sum, go to DATA.
  - Any other byte: drop silently, no error.
- DATA:
  - Accepts 16 bytes, index 0..15. Point k = {byte[2k][3:0], byte[2k+1]}, high byte first.
  - Even byte with nonzero `[7:4]`: format error.
  - Bytes go into the shadow registers; the live outputs are untouched.
  - After byte 15: go to CSUM (macro defined) or COMMIT (undefined).
- CSUM: accept one byte. If the 8-bit sum (mod 256) of header + 16 data bytes + this byte == 8'h00, go to COMMIT; otherwise error.
- COMMIT:
  - `byte_ready` low.
  - While `controlstate == 4'h7`: hold.
  - Otherwise: copy all shadows to `sgDP0..7` on one edge, set `table_valid`, pulse `load_done`, return to IDLE.
- Error (format, checksum or timeout):
  - Pulse `load_err`, discard the shadows, return to IDLE.
  - Live outputs and `table_valid` keep their previous values.
- Timeout:
  - A 16-bit counter runs in DATA and CSUM only. It clears on every accepted byte and increments each cycle without one.
  - Reaching `TIMEOUT_CYCLES` is an error.
- `byte_ready` = state != COMMIT and not `rst`; decoded from the state register.

## Timing
- Reset values:
  - `sgDP0..7` = 12'h000.
  - `table_valid`, `load_done`, `load_err`, `byte_ready` = 0.
  - State IDLE; counters 0.
- `byte_ready` goes high the first cycle after `rst` deasserts.
- `rst` mid-frame: the frame is abandoned and the reset values apply on that edge; no `load_err` pulse.
- Commit latency:
  - The final frame byte is accepted at edge N and the state is COMMIT after N.
  - If `controlstate != 4'h7` in the cycle after N, the outputs update and `load_done` = 1 after edge N+1.
  - Otherwise the commit happens on the first edge where `controlstate != 4'h7` is sampled.
- `load_err` asserts after the edge that accepts the offending byte, or after the edge where the timeout count is reached.
- `load_done` and `load_err` are never asserted together; each is high for exactly one cycle.
- Back-to-back frames: a header may be accepted on the cycle after the return to IDLE, so throughput is 18 bytes + 1 commit cycle per frame (17 + 1 without checksum).
- A byte equal to `HEADER_BYTE` in DATA or CSUM is treated as data; there is no resynchronisation mid-frame.

## Configuration
- `SG_LOADER_CHECKSUM_EN` defined:
  - Frame is header, 16 data bytes, checksum byte; CSUM state is present.
  - Checksum failure raises `load_err`.
- Undefined:
  - Frame is header plus 16 data bytes; CSUM state and sum logic are removed.
  - COMMIT follows the 16th data byte directly; only format and timeout errors exist.

## Test plan
- Reset, then frame A5, (01 23)×8, 3B with `controlstate = 4'h0` -> all `sgDP` = 12'h123, `table_valid` = 1, one `load_done` pulse one edge after byte 3B.
- Same frame but checksum 3C -> `load_err` pulse, `sgDP` stay 12'h000, `table_valid` = 0.
- Valid frame (points 12'hFFF; checksum = (0x100 − (0xA5 + 8×0x10E) mod 256) mod 256) sent while `controlstate = 4'h7` held 20 cycles -> `byte_ready` low and outputs unchanged for 20 cycles; commit on the first cycle with `controlstate = 4'h5`.
- Even data byte 8'h1F at index 4 -> `load_err` on that edge, previous table retained.
- `TIMEOUT_CYCLES = 8`: header then 3 data bytes, then `byte_valid` low -> `load_err` exactly 8 cycles after the last accepted byte; the next header is accepted normally.
- Junk bytes 00 FF 5A in IDLE, then a valid frame -> no error pulses, table committed; `rst` asserted mid-frame -> no pulses, outputs 0.
